// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS core.
// Outputs decode from current state plus IR opcode/funct.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        alu_zero,
  output logic        pc_cond_zero,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_ctrl,
  output logic        reg_write,
  output logic        IorD,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        instr_done,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JR       = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] FN_JR   = 6'd8;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  state_t state_nx;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] r_alu;
  logic       r_ok;
  logic       unused_bits;

  assign opcode      = inst[31:26];
  assign funct       = inst[5:0];
  assign unused_bits = ^inst[25:6];

  assign pc_cond_zero = (opcode == OP_BNE) ? ~alu_zero : alu_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      6'd32:   r_alu = ALU_ADD;
      6'd34:   r_alu = ALU_SUB;
      6'd36:   r_alu = ALU_AND;
      6'd37:   r_alu = ALU_OR;
      6'd42:   r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nx      = FETCH;
    reg_dst       = 2'd0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_src        = 2'd0;
    alu_ctrl      = ALU_ADD;
    reg_write     = 1'b0;
    IorD          = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'd1;
        pc_write  = 1'b1;
        state_nx  = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_R:         state_nx = (funct == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW: state_nx = MEM_ADDR;
          OP_ADDI,
          OP_SLTI:      state_nx = I_EXEC;
          OP_BEQ,
          OP_BNE:       state_nx = BRANCH;
          OP_J:         state_nx = JUMP;
          OP_JAL: begin
            // ALUOut still holds PC+4 from FETCH
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            state_nx  = JUMP;
          end
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nx  = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        state_nx = MEM_WB;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu;
        if (r_ok) begin
          state_nx = R_WB;
        end else begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      R_WB: begin
        reg_dst    = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_nx  = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_SUB;
        pc_src        = 2'd2;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'd1;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      JR: begin
        pc_src     = 2'd3;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_nx = FETCH;
    endcase

    // Held in FETCH during reset: selects stay, enables are masked
    if (rst) begin
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller.
// Per-instruction control-vector sequences checked every cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'd0;
  logic        alu_zero = 1'b0;
  logic        pc_cond_zero;
  logic [1:0]  reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic [2:0]  alu_ctrl;
  logic        reg_write;
  logic        IorD;
  logic        pc_write;
  logic        pc_write_cond;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        instr_done;
  logic        illegal_op;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .inst          (inst),
    .alu_zero      (alu_zero),
    .pc_cond_zero  (pc_cond_zero),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_ctrl      (alu_ctrl),
    .reg_write     (reg_write),
    .IorD          (IorD),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       reg_write;
    logic       IorD;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  ctl_t dut_v;
  assign dut_v = {reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
                  alu_ctrl, reg_write, IorD, pc_write, pc_write_cond,
                  ir_write, mem_read, mem_write, instr_done, illegal_op};

  ctl_t exp_q[$];
  ctl_t seq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic ctl_t idle();
    ctl_t v;
    v = '0;
    v.alu_ctrl = 3'b010;
    return v;
  endfunction

  // Expected per-cycle control vectors for one whole instruction
  function automatic void model(input logic [31:0] i);
    ctl_t f, d, x, y, z;
    logic [5:0] op, fn;
    logic ok;
    op = i[31:26];
    fn = i[5:0];
    seq.delete();
    f = idle(); f.mem_read = 1; f.ir_write = 1;
    f.alu_src_b = 2'd1; f.pc_write = 1;
    d = idle(); d.alu_src_b = 2'd3;
    x = idle(); y = idle(); z = idle();
    seq.push_back(f);
    case (op)
      6'd0: begin
        seq.push_back(d);
        if (fn == 6'd8) begin
          x.pc_src = 2'd3; x.pc_write = 1; x.instr_done = 1;
          seq.push_back(x);
        end else begin
          x.alu_src_a = 1;
          ok = 1;
          case (fn)
            6'd32:   x.alu_ctrl = 3'b010;
            6'd34:   x.alu_ctrl = 3'b110;
            6'd36:   x.alu_ctrl = 3'b000;
            6'd37:   x.alu_ctrl = 3'b001;
            6'd42:   x.alu_ctrl = 3'b111;
            default: ok = 0;
          endcase
          if (!ok) begin
            x.illegal_op = 1; x.instr_done = 1;
            seq.push_back(x);
          end else begin
            y.reg_dst = 2'd1; y.reg_write = 1; y.instr_done = 1;
            seq.push_back(x); seq.push_back(y);
          end
        end
      end
      6'd35, 6'd43: begin
        x.alu_src_a = 1; x.alu_src_b = 2'd2;
        y.IorD = 1;
        seq.push_back(d); seq.push_back(x);
        if (op == 6'd35) begin
          y.mem_read = 1;
          z.mem_to_reg = 1; z.reg_write = 1; z.instr_done = 1;
          seq.push_back(y); seq.push_back(z);
        end else begin
          y.mem_write = 1; y.instr_done = 1;
          seq.push_back(y);
        end
      end
      6'd8, 6'd10: begin
        x.alu_src_a = 1; x.alu_src_b = 2'd2;
        x.alu_ctrl = (op == 6'd10) ? 3'b111 : 3'b010;
        y.reg_write = 1; y.instr_done = 1;
        seq.push_back(d); seq.push_back(x); seq.push_back(y);
      end
      6'd4, 6'd5: begin
        x.alu_src_a = 1; x.alu_ctrl = 3'b110; x.pc_src = 2'd2;
        x.pc_write_cond = 1; x.instr_done = 1;
        seq.push_back(d); seq.push_back(x);
      end
      6'd2, 6'd3: begin
        if (op == 6'd3) begin
          d.reg_write = 1; d.reg_dst = 2'd2;
        end
        x.pc_src = 2'd1; x.pc_write = 1; x.instr_done = 1;
        seq.push_back(d); seq.push_back(x);
      end
      default: begin
        d.illegal_op = 1; d.instr_done = 1;
        seq.push_back(d);
      end
    endcase
  endfunction

  function automatic void pin(input string nm, input int got,
                              input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
    end
  endfunction

  always @(negedge clk) begin
    ctl_t e;
    logic pcz;
    pcz = (inst[31:26] == 6'd5) ? ~alu_zero : alu_zero;
    n_checks++;
    if (pc_cond_zero !== pcz) begin
      n_fail++;
      $display("FAIL pc_cond_zero t=%0t got=%b want=%b",
               $time, pc_cond_zero, pcz);
    end
    if (rst || exp_q.size() > 0) begin
      if (rst) begin
        e = idle();
        e.alu_src_b = 2'd1;
      end else begin
        e = exp_q.pop_front();
      end
      n_checks++;
      if (dut_v !== e) begin
        n_fail++;
        $display("FAIL ctl inst=%h rst=%b t=%0t got=%h want=%h",
                 inst, rst, $time, dut_v, e);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (exp_q.size() != 0 && k < 30);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout t=%0t left=%0d", $time, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [31:0] i, input logic az,
                     input int cyc, input int keep);
    wait_idle();
    #1;
    rst = 1'b0;
    inst = i;
    alu_zero = az;
    model(i);
    pin("cpi", seq.size(), cyc);
    for (int k = 0; k < seq.size() && k < keep; k++)
      exp_q.push_back(seq[k]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    run(32'h8C430004, 1'b0, 5, 99);
    run(32'h00622020, 1'b0, 4, 99);
    run(32'h00622022, 1'b1, 4, 99);
    run(32'h00622024, 1'b0, 4, 99);
    run(32'h00622025, 1'b0, 4, 99);
    run(32'h0062202A, 1'b0, 4, 99);
    run(32'h10220003, 1'b1, 3, 99);
    #1 pin("beq_pcz", int'(pc_cond_zero), 1);
    run(32'h14220003, 1'b1, 3, 99);
    #1 pin("bne_pcz", int'(pc_cond_zero), 0);
    run(32'h0C000010, 1'b0, 3, 99);
    @(posedge clk);
    #2 pin("jal_rw", int'(reg_write), 1);
    pin("jal_dst", int'(reg_dst), 2);
    run(32'h03E00008, 1'b0, 3, 99);
    run(32'h08000010, 1'b0, 3, 99);
    run(32'h20420005, 1'b0, 4, 99);
    run(32'h28420005, 1'b0, 4, 99);
    run(32'hAC430004, 1'b0, 4, 99);
    run(32'hFC000000, 1'b0, 2, 99);
    @(posedge clk);
    #2 pin("ill_op", int'(illegal_op), 1);
    pin("ill_done", int'(instr_done), 1);
    run(32'h0062203F, 1'b0, 3, 99);
    run(32'hAC430004, 1'b0, 4, 2);
    wait_idle();
    #1 rst = 1'b1;
    #1 pin("rst_mw", int'(mem_write), 0);
    repeat (2) @(posedge clk);
    run(32'h00622020, 1'b0, 4, 99);
    #1 pin("rel_irw", int'(ir_write), 1);
    run(32'h8C430004, 1'b0, 5, 99);
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle MIPS core: consumes the instruction register contents and the ALU zero flag from the datapath and drives every datapath select and write enable, plus memory read/write strobes. It is the control-side counterpart of the datapath: one instruction at a time, 3–5 cycles each, with outputs decoded from the current state plus opcode/funct.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- inst  in  32  IR contents: opcode [31:26], funct [5:0]
- alu_zero  in  1  ALU zero flag from datapath
- pc_cond_zero  out  1  branch condition to datapath: alu_zero for BEQ, ~alu_zero for BNE, else alu_zero
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=4, 2=sign-ext imm, 3=imm<<2
- pc_src  out  2  0=ALU result, 1=jump target, 2=ALUOut, 3=A
- alu_ctrl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- reg_write, IorD, pc_write, pc_write_cond, ir_write  out  1 each
- mem_read, mem_write  out  1 each
- instr_done  out  1  high in final cycle of each instruction
- illegal_op  out  1  high for the cycle an undefined opcode/funct is detected

## Operation
- Supported: R-type add(32) sub(34) and(36) or(37) slt(42) jr(8); lw(35) sw(43) beq(4) bne(5) j(2) jal(3) addi(8) slti(10).
- Unlisted outputs in any state are 0; alu_ctrl defaults to 010.
- FETCH: IorD=0, mem_read, ir_write, alu_src_a=0, alu_src_b=1, add, pc_src=0, pc_write. -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, add (branch target into ALUOut). If JAL: reg_write, reg_dst=2, mem_to_reg=0 (ALUOut still holds PC+4). Next: lw/sw->MEM_ADDR; R-type (non-jr)->R_EXEC; jr->JR; addi/slti->I_EXEC; beq/bne->BRANCH; j/jal->JUMP; undefined opcode -> illegal_op=1, instr_done=1, ->FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. lw->MEM_RD, sw->MEM_WR.
- MEM_RD: IorD=1, mem_read. ->MEM_WB.  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write, instr_done. ->FETCH.
- MEM_WR: IorD=1, mem_write, instr_done. ->FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_ctrl per funct. Undefined funct: illegal_op, instr_done, no write, ->FETCH; else ->R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write, instr_done. ->FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, add (addi) or slt (slti). ->I_WB.  I_WB: reg_dst=0, mem_to_reg=0, reg_write, instr_done. ->FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_src=2, pc_write_cond, instr_done. ->FETCH.
- JUMP: pc_src=1, pc_write, instr_done. ->FETCH.  JR: pc_src=3, pc_write, instr_done. ->FETCH.
- pc_cond_zero combinational from inst opcode and alu_zero in every state.

## Timing
- State register only sequential element; 4-bit, 13 states; outputs combinational from state and inst.
- Cycles per instruction: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3; undefined opcode 2, undefined funct 3.
- Reset: state -> FETCH immediately on rst rising; while rst=1, pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, instr_done, illegal_op forced 0; selects show FETCH values. First fetch occurs on first rising clk after rst deasserts.
- Reset mid-instruction aborts it with no further writes; unreachable state codes decode to FETCH next with all enables 0.
- inst is sampled only in DECODE and later states (IR stable after FETCH); changes on inst during FETCH have no effect on next state.

## Test plan
- Reset, release, inst=0x8C430004 (lw) -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write=1,mem_to_reg=1,reg_dst=0 only in cycle 5; instr_done once.
- inst=0x00622020 (add) -> R_EXEC alu_ctrl=010, alu_src_b=0; R_WB reg_dst=1, reg_write; 4 cycles. Repeat for sub/and/or/slt codes 110/000/001/111.
- beq (0x10220003) with alu_zero=1 -> pc_cond_zero=1 in BRANCH; bne with alu_zero=1 -> pc_cond_zero=0; both 3 cycles, pc_src=2.
- jal (0x0C000010) -> DECODE reg_write with reg_dst=2, mem_to_reg=0; JUMP pc_src=1, pc_write; jr (0x03E00008) -> JR pc_src=3.
- Opcode 0x3F -> illegal_op and instr_done in DECODE, back to FETCH, no reg_write/mem_write; R-type funct 0x3F -> illegal_op in R_EXEC.
- sw asserted rst during MEM_ADDR -> mem_write never asserted; after release FETCH outputs with ir_write=1 on next cycle.
